forwarding: RTL and testbench
=============================

FORWARDING -- requirements
Module: forwarding

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: IDinst  input  32  instruction in ID stage.
REQ-004 SHALL have ports: EXMinst  input  32  instruction in execute/memory stage.
REQ-005 SHALL have ports: WBinst  input  32  instruction in writeback stage.
REQ-006 SHALL have ports: IDEXMMEMWen  input  4  byte write enables of the EXM-stage instruction; nonzero means store.
REQ-007 SHALL have ports: EXMWBRegWen  input  1  WB-stage instruction writes rd.
REQ-008 SHALL have ports: IDEXMRegWen  input  1  EXM-stage instruction writes rd; reserved, no effect on any output.
REQ-009 SHALL have outputs regq1src, regq2src, alurs1src, alurs2src, memdsrc, branchrs1src, branchrs2src, each 1 bit; 1 = take WB writeback data, 0 = normal source.
REQ-010 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-011 Fields: rd=[11:7], rs1=[19:15], rs2=[24:20], opcode=[6:0].
REQ-012 wbhit(r) SHALL be 1 iff EXMWBRegWen=1 and WBinst.rd=r and r!=0 and warm=1.
REQ-013 Opcode classes: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JALR=1100111; any other opcode uses neither rs1 nor rs2.
REQ-014 regq1src SHALL be wbhit(IDinst.rs1) when the ID opcode is R, I, LOAD, STORE, BRANCH or JALR, else 0.
REQ-015 regq2src SHALL be wbhit(IDinst.rs2) when the ID opcode is R, STORE or BRANCH, else 0.
REQ-016 alurs1src SHALL be wbhit(EXMinst.rs1) when the EXM opcode is R, I, LOAD, STORE or JALR, else 0.
REQ-017 alurs2src SHALL be wbhit(EXMinst.rs2) when the EXM opcode is R, else 0.
REQ-018 memdsrc SHALL be wbhit(EXMinst.rs2) when the EXM opcode is STORE and IDEXMMEMWen!=0, else 0.
REQ-019 branchrs1src and branchrs2src SHALL be wbhit(EXMinst.rs1) and wbhit(EXMinst.rs2) respectively when the EXM opcode is BRANCH, else 0.
REQ-020 All seven outputs SHALL be combinational in the instruction and enable inputs, with zero-cycle latency.
REQ-021 WB data from loads SHALL be forwarded exactly as ALU results; no stall is generated.
REQ-022 A 2-bit saturating warm-up counter SHALL increment on each rising clk edge while rst_n=1 and below 2.
REQ-023 warm SHALL be 1 iff the counter equals 2.
REQ-024 rd=x0 SHALL never be forwarded.

Reset
REQ-025 When rst_n=0, the counter SHALL clear to 0 immediately; warm=0 and all outputs SHALL be 0 regardless of the other inputs.
REQ-026 After rst_n rises, outputs SHALL become valid from the second rising clk edge onward.
REQ-027 A reset asserted mid-operation SHALL force all outputs to 0 asynchronously.

Verification (warm=1, EXMWBRegWen=1 unless stated)
REQ-028 ALU-ALU: EXMinst=00517633 (and x12,x2,x5), WBinst=40308133 (rd=x2) -> alurs1src=1, all others 0; EXMinst=0022f633 -> alurs2src=1 only.
REQ-029 ALU-MEM: EXMinst=0011a023 (sw x1,0(x3)), WBinst=06410093 (rd=x1), IDEXMMEMWen=F -> memdsrc=1, alurs2src=0; EXMinst=0030a023 (sw x3,0(x1)) -> alurs1src=1 only.
REQ-030 MEM-ALU: WBinst=0050a103 (lw x2) with EXMinst=00517633 -> alurs1src=1 only; with EXMinst=0022f633 -> alurs2src=1 only.
REQ-031 Branch: WBinst=06408093 (rd=x1), EXMinst=f8208ee3 (beq x1,x2) -> branchrs1src=1 only; EXMinst=f81118e3 (bne x2,x1) -> branchrs2src=1 only.
REQ-032 ID read: WBinst=06410093 (rd=x1), EXMinst=00000013, IDinst=06408093 -> regq1src=1 only; IDinst=00110133 -> regq2src=1 only; IDinst=f4209ee3 with WBinst=06410113 (rd=x2) -> regq2src=1.
REQ-033 Negative cases, with any of the hit stimuli above -> all outputs 0: EXMWBRegWen=0; WB rd=x0; rst_n=0; or fewer than 2 clk edges since reset release.

Source files
------------

// File: rtl/forwarding.sv
// rtl/forwarding.sv - WB-to-ID/EXM operand forwarding select with post-reset warm-up gate
module forwarding (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IDinst,
  input  logic [31:0] EXMinst,
  input  logic [31:0] WBinst,
  input  logic [3:0]  IDEXMMEMWen,
  input  logic        EXMWBRegWen,
  input  logic        IDEXMRegWen,
  output logic        regq1src,
  output logic        regq2src,
  output logic        alurs1src,
  output logic        alurs2src,
  output logic        memdsrc,
  output logic        branchrs1src,
  output logic        branchrs2src
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0] cnt_q, cnt_d;
  logic       warm;

  // Instruction fields
  logic [6:0] id_op, exm_op;
  logic [4:0] id_rs1, id_rs2, exm_rs1, exm_rs2, wb_rd;

  // The EXM-stage rd write enable is intentionally ignored; folded here so it is visibly consumed.
  logic unused_inputs;
  assign unused_inputs = ^{IDEXMRegWen, IDinst[31:25], IDinst[14:7], EXMinst[31:25],
                           EXMinst[14:7], WBinst[31:12], WBinst[6:0]};

  assign id_op   = IDinst[6:0];
  assign id_rs1  = IDinst[19:15];
  assign id_rs2  = IDinst[24:20];
  assign exm_op  = EXMinst[6:0];
  assign exm_rs1 = EXMinst[19:15];
  assign exm_rs2 = EXMinst[24:20];
  assign wb_rd   = WBinst[11:7];

  // Warm-up counter next state: saturate at 2
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q < 2'd2) cnt_d = cnt_q + 2'd1;
  end

  // Warm-up counter register; cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 2'd0;
    else        cnt_q <= cnt_d;
  end

  // rst_n is also ANDed in so outputs drop in the same instant reset asserts
  assign warm = (cnt_q == 2'd2) && rst_n;

  function automatic logic wbhit(input logic [4:0] r, input logic [4:0] rd,
                                 input logic wen, input logic w);
    return wen && (rd == r) && (r != 5'd0) && w;
  endfunction

  // Per-consumer forwarding selects; loads and ALU results forward identically, no stall
  always_comb begin
    regq1src     = 1'b0;
    regq2src     = 1'b0;
    alurs1src    = 1'b0;
    alurs2src    = 1'b0;
    memdsrc      = 1'b0;
    branchrs1src = 1'b0;
    branchrs2src = 1'b0;

    if (id_op == OP_R || id_op == OP_I || id_op == OP_LOAD || id_op == OP_STORE ||
        id_op == OP_BRANCH || id_op == OP_JALR)
      regq1src = wbhit(id_rs1, wb_rd, EXMWBRegWen, warm);

    if (id_op == OP_R || id_op == OP_STORE || id_op == OP_BRANCH)
      regq2src = wbhit(id_rs2, wb_rd, EXMWBRegWen, warm);

    if (exm_op == OP_R || exm_op == OP_I || exm_op == OP_LOAD || exm_op == OP_STORE ||
        exm_op == OP_JALR)
      alurs1src = wbhit(exm_rs1, wb_rd, EXMWBRegWen, warm);

    if (exm_op == OP_R)
      alurs2src = wbhit(exm_rs2, wb_rd, EXMWBRegWen, warm);

    if (exm_op == OP_STORE && IDEXMMEMWen != 4'd0)
      memdsrc = wbhit(exm_rs2, wb_rd, EXMWBRegWen, warm);

    if (exm_op == OP_BRANCH) begin
      branchrs1src = wbhit(exm_rs1, wb_rd, EXMWBRegWen, warm);
      branchrs2src = wbhit(exm_rs2, wb_rd, EXMWBRegWen, warm);
    end
  end

endmodule

// File: tb/tb_forwarding.sv
// tb/tb_forwarding.sv - scoreboard bench for forwarding with directed vectors
module tb_forwarding;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IDinst, EXMinst, WBinst;
  logic [3:0]  IDEXMMEMWen;
  logic        EXMWBRegWen, IDEXMRegWen;
  logic        regq1src, regq2src, alurs1src, alurs2src, memdsrc, branchrs1src, branchrs2src;

  forwarding dut (
    .clk(clk), .rst_n(rst_n), .IDinst(IDinst), .EXMinst(EXMinst), .WBinst(WBinst),
    .IDEXMMEMWen(IDEXMMEMWen), .EXMWBRegWen(EXMWBRegWen), .IDEXMRegWen(IDEXMRegWen),
    .regq1src(regq1src), .regq2src(regq2src), .alurs1src(alurs1src), .alurs2src(alurs2src),
    .memdsrc(memdsrc), .branchrs1src(branchrs1src), .branchrs2src(branchrs2src)
  );

  always #5 clk = ~clk;

  // Expected bit order: {regq1, regq2, alurs1, alurs2, memd, br1, br2}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] RQ1  = 7'b1000000;
  localparam logic [6:0] RQ2  = 7'b0100000;
  localparam logic [6:0] AR1  = 7'b0010000;
  localparam logic [6:0] AR2  = 7'b0001000;
  localparam logic [6:0] MEMD = 7'b0000100;
  localparam logic [6:0] BR1  = 7'b0000010;
  localparam logic [6:0] BR2  = 7'b0000001;

  typedef struct {
    logic [6:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Drive one vector just after a rising edge and queue its expectation
  task automatic apply(input string name, input logic [31:0] id, input logic [31:0] exm,
                       input logic [31:0] wb, input logic [3:0] wen, input logic rwen,
                       input logic [6:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    IDinst      = id;
    EXMinst     = exm;
    WBinst      = wb;
    IDEXMMEMWen = wen;
    EXMWBRegWen = rwen;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compare on the falling edge whenever an expectation is pending
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] got;
      e   = exp_q.pop_front();
      got = {regq1src, regq2src, alurs1src, alurs2src, memdsrc, branchrs1src, branchrs2src};
      n_checks++;
      if (got === e.exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
    end
  end

  initial begin
    rst_n       = 1'b0;
    IDinst      = 32'h00000013;
    EXMinst     = 32'h00000013;
    WBinst      = 32'h00000013;
    IDEXMMEMWen = 4'h0;
    EXMWBRegWen = 1'b1;
    IDEXMRegWen = 1'b0;

    // Reset held: hit stimulus must be suppressed
    apply("reset_held",   32'h00000013, 32'h00517633, 32'h40308133, 4'h0, 1'b1, NONE);
    apply("reset_held2",  32'h06408093, 32'h00517633, 32'h40308133, 4'h0, 1'b1, NONE);

    // Release reset; counter 0 then 1 still gate, 2 opens
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply("warm_cnt1",    32'h00000013, 32'h00517633, 32'h40308133, 4'h0, 1'b1, NONE);
    apply("warm_cnt2",    32'h00000013, 32'h00517633, 32'h40308133, 4'h0, 1'b1, AR1);

    // ALU-ALU
    apply("alu_alu_rs1",  32'h00000013, 32'h00517633, 32'h40308133, 4'h0, 1'b1, AR1);
    apply("alu_alu_rs2",  32'h00000013, 32'h0022f633, 32'h40308133, 4'h0, 1'b1, AR2);
    // ALU-MEM
    apply("alu_mem_data", 32'h00000013, 32'h0011a023, 32'h06410093, 4'hF, 1'b1, MEMD);
    apply("alu_mem_addr", 32'h00000013, 32'h0030a023, 32'h06410093, 4'hF, 1'b1, AR1);
    apply("store_no_wen", 32'h00000013, 32'h0011a023, 32'h06410093, 4'h0, 1'b1, NONE);
    // MEM-ALU
    apply("mem_alu_rs1",  32'h00000013, 32'h00517633, 32'h0050a103, 4'h0, 1'b1, AR1);
    apply("mem_alu_rs2",  32'h00000013, 32'h0022f633, 32'h0050a103, 4'h0, 1'b1, AR2);
    // Branch
    apply("branch_rs1",   32'h00000013, 32'hf8208ee3, 32'h06408093, 4'h0, 1'b1, BR1);
    apply("branch_rs2",   32'h00000013, 32'hf81118e3, 32'h06408093, 4'h0, 1'b1, BR2);
    // ID read
    apply("id_rs1_i",     32'h06408093, 32'h00000013, 32'h06410093, 4'h0, 1'b1, RQ1);
    apply("id_rs2_r",     32'h00110133, 32'h00000013, 32'h06410093, 4'h0, 1'b1, RQ2);
    apply("id_rs2_br",    32'hf4209ee3, 32'h00000013, 32'h06410113, 4'h0, 1'b1, RQ2);
    // JALR in both stages uses rs1 only
    apply("jalr_both",    32'h000100e7, 32'h000100e7, 32'h40308133, 4'h0, 1'b1, RQ1 | AR1);
    // Opcode classes that ignore a matching field
    apply("addi_rs2fld",  32'h00000013, 32'h00228613, 32'h40308133, 4'h0, 1'b1, NONE);
    apply("lui_rs1fld",   32'h00010637, 32'h00010637, 32'h40308133, 4'h0, 1'b1, NONE);
    // Negatives
    apply("no_regwen",    32'h00000013, 32'h00517633, 32'h40308133, 4'h0, 1'b0, NONE);
    apply("wb_rd_x0",     32'h00000013, 32'h00007633, 32'h40300033, 4'h0, 1'b1, NONE);
    // Reserved enable must have no effect
    @(posedge clk);
    #1 IDEXMRegWen = 1'b1;
    apply("exm_regwen_x", 32'h00000013, 32'h00517633, 32'h40308133, 4'h0, 1'b1, AR1);

    // Mid-operation reset drops outputs asynchronously, then warm-up repeats
    begin
      exp_t e;
      @(posedge clk);
      #2 rst_n = 1'b0;
      e.exp  = NONE;
      e.name = "mid_reset";
      exp_q.push_back(e);
    end
    apply("reset_held3",  32'h00000013, 32'h0022f633, 32'h40308133, 4'h0, 1'b1, NONE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply("rewarm_cnt1",  32'h00000013, 32'h0022f633, 32'h40308133, 4'h0, 1'b1, NONE);
    apply("rewarm_cnt2",  32'h00000013, 32'h0022f633, 32'h40308133, 4'h0, 1'b1, AR2);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
